aes_cbc_encr: RTL
=================

# aes_cbc_encr

CBC-mode AES-128 encryption engine: the transmit-side counterpart of the CBC decrypt path. It XORs each plaintext block with a chaining value, which is the IV or the previous ciphertext, then passes the result through the combinational AES-128 encryption core. The core is given a programmable multicycle settle window. The ciphertext is registered and updates the chaining value. Valid/ready handshakes sit on both sides, between the bus/DMA front end and the ciphertext sink.

## Interface
- SETTLE_CYCLES, 2, clock cycles the combinational core is given to settle (multicycle path); legal range 1..15
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- key  in  128  AES-128 key
- iv  in  128  initialization vector
- iv_load  in  1  pulse: load chaining register from iv (honored in IDLE only)
- in_valid  in  1  plaintext block valid
- in_ready  out  1  block accepted when in_valid && in_ready
- in_data  in  128  plaintext block
- out_valid  out  1  ciphertext valid
- out_ready  in  1  sink accepts when out_valid && out_ready
- out_data  out  128  ciphertext block
- busy  out  1  high whenever state != IDLE

## Operation
- Reset values:
  - state IDLE
  - out_valid 0, busy 0, in_ready 1
  - out_data 0, chain_q 0, blk_q 0, cnt 0
- FSM states: IDLE, CALC, HOLD.
- IDLE:
  - in_ready=1.
  - iv_load alone: chain_q <= iv.
  - Accept (in_valid): blk_q <= in_data ^ (iv_load ? iv : chain_q), so iv_load wins in the same cycle. cnt <= SETTLE_CYCLES-1. Go to CALC.
- CALC:
  - in_ready=0.
  - The core input is blk_q, registered, so the core sees stable operands.
  - If cnt==0: out_data <= core_out, chain_q <= core_out, out_valid <= 1, go to HOLD. Otherwise cnt decrements.
- HOLD:
  - out_data is held stable and out_valid stays 1 until out_ready.
  - On handshake: out_valid <= 0, go to IDLE.
- iv_load in CALC/HOLD is ignored; the chaining value is unaffected.
- in_valid while not ready is not accepted. The source must hold in_data until the handshake.
- Chaining persists across messages until iv_load or reset.
- Reset mid-operation:
  - The in-flight block is dropped and no out_valid is produced.
  - chain_q is cleared to 0, so a new IV must be loaded.

## Timing
- Latency: accept on edge t → out_valid rises on edge t+SETTLE_CYCLES.
- A HOLD→IDLE handshake on edge u allows the next accept on edge u+1.
- Maximum throughput is one block per SETTLE_CYCLES+2 cycles.
- out_data and out_valid are registered outputs.
- in_ready and busy are decoded directly from state; there is no combinational path from in_valid or out_ready.
- Timing constraints: the path blk_q/key → out_data/chain_q is a multicycle path of SETTLE_CYCLES. Without AES_CBC_ENCR_KEYLATCH_EN, key → out_data/chain_q carries the same constraint.

## Configuration
- AES_CBC_ENCR_KEYLATCH_EN defined:
  - key_q <= key at each accept, and the core uses key_q.
  - key may change freely after the accept edge.
- Undefined:
  - The core uses key directly.
  - key must be stable from the accept edge through the out_valid edge; a change in that window gives undefined ciphertext.
  - Saves 128 flops.

## Structure
- Shared package aes_pkg:
  - AES_BLK_W=128, AES_KEY_W=128
  - FSM state encoding typedef (IDLE/CALC/HOLD)
  - SETTLE_CYCLES default
- One sub-module: aes_encr_top, the combinational AES-128 encryption core (ports rst, in, key, out), with rst tied to 0.
- This block holds the FSM, settle counter, chaining register, input XOR and output register.

## Test plan
- Reset: hold rst_n low, then release → out_valid=0, in_ready=1, busy=0, out_data=0.
- First block (SP 800-38A F.2.1), SETTLE_CYCLES=2:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, iv_load with iv 000102030405060708090a0b0c0d0e0f, then P1 6bc1bee22e409f96e93d7e117393172a.
  - Response: out_data 7649abac8119b246cee98e9b12e9197d, out_valid exactly 2 edges after the accept.
- Chaining: with no IV reload, P2 ae2d8a571e03ac9c9eb76fac45af8e51 → 5086cb9b507219ee95db113a917678b2.
- Backpressure:
  - Stimulus: out_ready low for 5 cycles while in_valid is held high with P2.
  - Response: out_data stable, in_ready=0, no second accept. Accept happens on the cycle after the output handshake.
- Simultaneous iv_load and in_valid in IDLE: the iv is used for the XOR, so the result is P1 → 7649abac8119b246cee98e9b12e9197d regardless of the old chain value.
- Reset mid-operation:
  - Stimulus: rst_n asserted during CALC.
  - Response: no out_valid. After release, P1 with no iv_load uses chain 0 → 3ad77bb40d7a3660a89ecaf32466ef97.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: block/key widths, engine FSM encoding and the
// SubBytes/ShiftRows/MixColumns/key-schedule helpers used by the combinational core.
package aes_pkg;
    localparam int AES_BLK_W         = 128;
    localparam int AES_KEY_W         = 128;
    localparam int SETTLE_CYCLES_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [127:0] next_round_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64]  ^ w0;
        w2 = k[63:32]  ^ w1;
        w3 = k[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Byte n of a block is [127-8n -: 8]; state row r, column c holds byte r+4c.
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [127:0] sr, mc;
        logic [7:0]   a0, a1, a2, a3;
        sr = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[127-8*(r+4*c) -: 8] = SBOX[s[127-8*(r+4*((c+r)%4)) -: 8]];
        mc = sr;
        for (int c = 0; c < 4; c++) begin
            a0 = sr[127-32*c -: 8];
            a1 = sr[119-32*c -: 8];
            a2 = sr[111-32*c -: 8];
            a3 = sr[103-32*c -: 8];
            mc[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                  a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                  a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                  xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return (last ? sr : mc) ^ rk;
    endfunction
endpackage

// File: rtl/aes_cbc_encr_if.sv
// Plaintext-in / ciphertext-out valid-ready streams of the CBC encryption engine.
// master: block source and ciphertext sink; slave: the engine.
interface aes_cbc_encr_if;
    import aes_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [AES_BLK_W-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [AES_BLK_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/aes_encr_top.sv
// Combinational AES-128 encryption core: ten rounds with the key schedule unrolled inline.
// Purely combinational; the caller budgets a multicycle settle window around it.
module aes_encr_top
    import aes_pkg::*;
(
    input  logic                 rst,
    input  logic [AES_BLK_W-1:0] in,
    input  logic [AES_KEY_W-1:0] key,
    output logic [AES_BLK_W-1:0] out
);
    always_comb begin
        logic [AES_BLK_W-1:0] st;
        logic [AES_KEY_W-1:0] rk;
        logic [7:0]           rc;
        st = in ^ key;
        rk = key;
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            rk = next_round_key(rk, rc);
            rc = xtime(rc);
            st = aes_round(st, rk, r == 10);
        end
        out = rst ? '0 : st;
    end
endmodule

// File: rtl/aes_cbc_encr.sv
// CBC AES-128 encrypt engine; AES_CBC_ENCR_KEYLATCH_EN latches key at accept.
// Latency: accept edge t -> out_valid at t+SETTLE_CYCLES; one block per SETTLE_CYCLES+2 cycles.
// Backpressure: in_ready only in IDLE; ciphertext held in HOLD until out_ready.
module aes_cbc_encr
    import aes_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [AES_KEY_W-1:0] key,
    input  logic [AES_BLK_W-1:0] iv,
    input  logic                 iv_load,
    output logic                 busy,
    aes_cbc_encr_if.slave        bus
);
    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [AES_BLK_W-1:0] blk_q, blk_d;
    logic [AES_BLK_W-1:0] chain_q, chain_d;
    logic [AES_BLK_W-1:0] dout_q, dout_d;
    logic                 ovld_q, ovld_d;
    logic [AES_KEY_W-1:0] core_key;
    logic [AES_BLK_W-1:0] core_out;
    logic                 accept;

    assign accept = (state_q == ST_IDLE) && bus.in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept)         state_d = ST_CALC;
            ST_CALC: if (cnt_q == '0)    state_d = ST_HOLD;
            ST_HOLD: if (bus.out_ready)  state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready = (state_q == ST_IDLE);
        busy         = (state_q != ST_IDLE);
    end

    // A same-cycle iv_load takes precedence over the stored chain for the XOR.
    always_comb begin
        cnt_d   = cnt_q;
        blk_d   = blk_q;
        chain_d = chain_q;
        dout_d  = dout_q;
        ovld_d  = ovld_q;
        unique case (state_q)
            ST_IDLE: begin
                if (iv_load) chain_d = iv;
                if (accept) begin
                    blk_d = bus.in_data ^ (iv_load ? iv : chain_q);
                    cnt_d = CNT_INIT;
                end
            end
            ST_CALC: begin
                if (cnt_q == '0) begin
                    dout_d  = core_out;
                    chain_d = core_out;
                    ovld_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HOLD: if (bus.out_ready) ovld_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            blk_q   <= '0;
            chain_q <= '0;
            dout_q  <= '0;
            ovld_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
            chain_q <= chain_d;
            dout_q  <= dout_d;
            ovld_q  <= ovld_d;
        end
    end

`ifdef AES_CBC_ENCR_KEYLATCH_EN
    logic [AES_KEY_W-1:0] key_q, key_d;
    assign key_d = accept ? key : key_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) key_q <= '0;
        else        key_q <= key_d;
    end
    assign core_key = key_q;
`else
    // The source keeps key stable from accept through out_valid.
    assign core_key = key;
`endif

    aes_encr_top u_core (
        .rst (1'b0),
        .in  (blk_q),
        .key (core_key),
        .out (core_out)
    );

    assign bus.out_valid = ovld_q;
    assign bus.out_data  = dout_q;
endmodule
